// File: rtl/state_uart_tx.sv
// state_uart_tx: 8N1 UART transmitter fed by the state byte stream.
// A one-byte holding register sits in front of the shifter, so the next byte is
// accepted while the current frame is on the wire. Frames go out back to back.
module state_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       StopLast = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [BaudW-1:0]  r_baud;
    logic [BaudW-1:0]  w_baud_d;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_d;
    logic [7:0]        r_shift;
    logic [7:0]        r_hold_byte;
    logic              r_hold_full;
    logic              r_ready_en;
    logic              r_tx;
    logic              r_busy;
    logic              r_frame_done;

    logic              w_accept;
    logic              w_load;
    logic              w_stop_done;
    logic              w_baud_end;
    logic              w_tx_d;
    logic              w_busy_d;

    assign in_ready   = r_ready_en & ~r_hold_full;
    assign w_accept   = in_valid & in_ready;
    assign w_baud_end = (r_baud == BaudLast);

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state, baud/bit counter and holding-register load decisions.
    always_comb begin
        w_state_d   = r_state;
        w_baud_d    = r_baud;
        w_bit_d     = r_bit;
        w_load      = 1'b0;
        w_stop_done = 1'b0;
        case (r_state)
            StIdle: begin
                w_baud_d = '0;
                w_bit_d  = '0;
                if (r_hold_full) begin
                    w_load    = 1'b1;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                if (w_baud_end) begin
                    w_baud_d  = '0;
                    w_bit_d   = '0;
                    w_state_d = StData;
                end else begin
                    w_baud_d = r_baud + 1'b1;
                end
            end
            StData: begin
                if (w_baud_end) begin
                    w_baud_d = '0;
                    if (r_bit == 3'd7) begin
                        w_bit_d   = '0;
                        w_state_d = StStop;
                    end else begin
                        w_bit_d = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_d = r_baud + 1'b1;
                end
            end
            StStop: begin
                if (w_baud_end) begin
                    w_baud_d = '0;
                    if (r_bit == StopLast) begin
                        // Frame ends here; a pending byte goes straight to START.
                        w_bit_d     = '0;
                        w_stop_done = 1'b1;
                        if (r_hold_full) begin
                            w_load    = 1'b1;
                            w_state_d = StStart;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end else begin
                        w_bit_d = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_d = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Output decode; registered below so every level lasts exactly CLKS_PER_BIT cycles.
    always_comb begin
        w_tx_d = 1'b1;
        case (r_state)
            StStart: w_tx_d = 1'b0;
            StData:  w_tx_d = r_shift[r_bit];
            default: w_tx_d = 1'b1;
        endcase
        w_busy_d = (r_state != StIdle) | r_hold_full;
    end

    // Counters, holding register and shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_hold_byte <= '0;
            r_hold_full <= 1'b0;
            r_ready_en  <= 1'b0;
        end else begin
            r_baud     <= w_baud_d;
            r_bit      <= w_bit_d;
            r_ready_en <= 1'b1;
            if (w_load) begin
                r_shift <= r_hold_byte;
            end
            if (w_accept) begin
                r_hold_byte <= in_byte;
            end
            // An accept in the load cycle refills the register immediately.
            if (w_accept) begin
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_tx         <= w_tx_d;
            r_busy       <= w_busy_d;
            r_frame_done <= w_stop_done;
        end
    end

endmodule

// File: tb/tb_state_uart_tx.sv
`timescale 1ns/1ps
// Bench for state_uart_tx: two instances (4 clk/bit 1 stop, 3 clk/bit 2 stop).
// Stimulus pushes hand-written expected bytes; per-DUT monitors decode tx and compare.
module tb_state_uart_tx;

    localparam int unsigned C0 = 4;
    localparam int unsigned S0 = 1;
    localparam int unsigned C1 = 3;
    localparam int unsigned S1 = 2;

    logic       clk = 1'b0;
    logic       rst_n0, rst_n1;
    logic [7:0] in_byte0, in_byte1;
    logic       in_valid0, in_valid1;
    logic       in_ready0, in_ready1;
    logic       tx0, tx1, busy0, busy1, fd0, fd1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_cnt0 = 0;
    int fd_cnt1 = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         start_t0[$];
    int         start_t1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fd0) fd_cnt0 <= fd_cnt0 + 1;
        if (fd1) fd_cnt1 <= fd_cnt1 + 1;
    end

    state_uart_tx #(.CLKS_PER_BIT(C0), .STOP_BITS(S0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n0),
        .in_byte    (in_byte0),
        .in_valid   (in_valid0),
        .in_ready   (in_ready0),
        .tx         (tx0),
        .busy       (busy0),
        .frame_done (fd0)
    );

    state_uart_tx #(.CLKS_PER_BIT(C1), .STOP_BITS(S1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n1),
        .in_byte    (in_byte1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .tx         (tx1),
        .busy       (busy1),
        .frame_done (fd1)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    function automatic logic get_tx(input int id);
        return (id == 0) ? tx0 : tx1;
    endfunction

    function automatic logic get_fd(input int id);
        return (id == 0) ? fd0 : fd1;
    endfunction

    function automatic logic get_rst(input int id);
        return (id == 0) ? rst_n0 : rst_n1;
    endfunction

    // Decode one frame per falling start edge and compare every cycle of it.
    task automatic monitor(input int id);
        int         c, s, len, bad, fd_bad, idx;
        logic [7:0] b;
        logic       lvl, aborted;
        c   = (id == 0) ? C0 : C1;
        s   = (id == 0) ? S0 : S1;
        len = (9 + s) * c;
        forever begin
            @(negedge clk);
            if (get_rst(id) && get_tx(id) == 1'b0) begin
                if (id == 0) start_t0.push_back(cyc);
                else         start_t1.push_back(cyc);
                b = 8'h00;
                if (id == 0 && exp_q0.size() > 0)      b = exp_q0.pop_front();
                else if (id == 1 && exp_q1.size() > 0) b = exp_q1.pop_front();
                else check($sformatf("dut%0d unexpected frame", id), 1, 0);
                bad     = 0;
                fd_bad  = 0;
                aborted = 1'b0;
                for (int i = 0; i < len; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!get_rst(id)) begin
                        aborted = 1'b1;
                        break;
                    end
                    idx = i / c;
                    if (idx == 0)      lvl = 1'b0;
                    else if (idx <= 8) lvl = b[idx-1];
                    else               lvl = 1'b1;
                    if (get_tx(id) != lvl) bad++;
                    if (get_fd(id) != (i == len - 1)) fd_bad++;
                end
                if (!aborted) begin
                    check($sformatf("dut%0d frame 0x%02h bit errors", id, b), bad, 0);
                    check($sformatf("dut%0d frame 0x%02h frame_done pos", id, b), fd_bad, 0);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Present a byte and wait for the handshake; acc_t is the accepting edge number.
    task automatic send(input int id, input logic [7:0] b, input bit expect_out,
                        output int acc_t);
        bit done = 1'b0;
        acc_t = -1;
        if (expect_out) begin
            if (id == 0) exp_q0.push_back(b);
            else         exp_q1.push_back(b);
        end
        if (id == 0) begin in_byte0 = b; in_valid0 = 1'b1; end
        else         begin in_byte1 = b; in_valid1 = 1'b1; end
        for (int n = 0; n < 500 && !done; n++) begin
            @(negedge clk);
            if ((id == 0) ? in_ready0 : in_ready1) begin
                acc_t = cyc + 1;
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check($sformatf("dut%0d accept 0x%02h timeout", id, b), 0, 1);
    endtask

    task automatic drop_valid(input int id);
        if (id == 0) in_valid0 = 1'b0;
        else         in_valid1 = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        bit idle = 1'b0;
        repeat (3) @(posedge clk);
        for (int n = 0; n < 2000 && !idle; n++) begin
            @(negedge clk);
            if (((id == 0) ? busy0 : busy1) == 1'b0) idle = 1'b1;
        end
        if (!idle) check($sformatf("dut%0d idle timeout", id), 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, a3, f;
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        in_byte0 = '0; in_byte1 = '0;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        #23;
        check("reset tx0", tx0, 1);
        check("reset busy0", busy0, 0);
        check("reset frame_done0", fd0, 0);
        check("reset in_ready0", in_ready0, 0);
        check("reset tx1", tx1, 1);
        check("reset in_ready1", in_ready1, 0);
        @(negedge clk); rst_n0 = 1'b1; rst_n1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single byte 0x0A.
        f = fd_cnt0;
        send(0, 8'h0A, 1'b1, a0);
        drop_valid(0);
        wait_idle(0);
        check("0x0A start latency", start_t0[start_t0.size()-1] - a0, 2);
        check("0x0A frame_done count", fd_cnt0 - f, 1);
        check("0x0A tx idle after", tx0, 1);
        check("0x0A busy low after", busy0, 0);

        // Back to back 0x55, 0xFA.
        f = fd_cnt0;
        send(0, 8'h55, 1'b1, a0);
        send(0, 8'hFA, 1'b1, a1);
        drop_valid(0);
        wait_idle(0);
        check("b2b start spacing",
              start_t0[start_t0.size()-1] - start_t0[start_t0.size()-2], 40);
        check("b2b frame_done count", fd_cnt0 - f, 2);

        // Backpressured stream 0A 55 FA CE.
        f = fd_cnt0;
        send(0, 8'h0A, 1'b1, a0);
        send(0, 8'h55, 1'b1, a1);
        check("stream in_ready low after 2nd accept", in_ready0, 0);
        send(0, 8'hFA, 1'b1, a2);
        send(0, 8'hCE, 1'b1, a3);
        drop_valid(0);
        wait_idle(0);
        check("stream accept 1->2", a1 - a0, 2);
        check("stream accept 2->3", a2 - a1, 40);
        check("stream accept 3->4", a3 - a2, 40);
        check("stream frame_done count", fd_cnt0 - f, 4);

        // Two stop bits, 3 clk/bit, 0xCE.
        f = fd_cnt1;
        send(1, 8'hCE, 1'b1, a0);
        drop_valid(1);
        wait_idle(1);
        check("2stop start latency", start_t1[start_t1.size()-1] - a0, 2);
        check("2stop frame_done count", fd_cnt1 - f, 1);
        check("2stop busy low after", busy1, 0);

        // Reset during data bit 3 of 0xA2 with 0x11 held.
        f = fd_cnt0;
        send(0, 8'hA2, 1'b1, a0);
        send(0, 8'h11, 1'b0, a1);
        drop_valid(0);
        while (cyc < a0 + 2 + 4 * C0 + 1) @(posedge clk);
        #2;
        check("mid-frame tx before reset", tx0, 0);
        rst_n0 = 1'b0;
        #1;
        check("reset async tx", tx0, 1);
        check("reset async busy", busy0, 0);
        check("reset async in_ready", in_ready0, 0);
        in_byte0  = 8'h5E;
        in_valid0 = 1'b1;
        exp_q0.push_back(8'h5E);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n0 = 1'b1;
        #2;
        check("in_ready before first edge", in_ready0, 0);
        @(posedge clk); #1;
        check("in_ready after first edge", in_ready0, 1);
        @(posedge clk); #1;
        check("in_ready after second edge (accepted)", in_ready0, 0);
        a2 = cyc;
        drop_valid(0);
        wait_idle(0);
        check("post-reset start latency", start_t0[start_t0.size()-1] - a2, 2);
        check("post-reset frame_done count", fd_cnt0 - f, 1);

        check("dut0 expected queue drained", exp_q0.size(), 0);
        check("dut1 expected queue drained", exp_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/state_uart_tx.md
Name: state_uart_tx

Overview:
- 8N1 UART transmitter that consumes the state-dump byte stream (header 0A 55 FA CE, password, hashes, footer A2 5E FA CE) and drives it onto the host serial line.
- Sits directly downstream of the state byte source.
- One-byte holding register plus shift register, so the next byte is accepted while the current frame is on the wire. Back-to-back frames have no idle gap.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_byte  input  8  byte to transmit.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  holding register can accept; a transfer occurs on a posedge where in_valid && in_ready.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in flight or the holding register is full.
- frame_done  output  1  one-cycle pulse on the cycle after the last stop bit ends.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - tx=1, busy=0, frame_done=0, in_ready=0.
  - state=IDLE, hold_full=0, baud and bit counters 0.
- A ready_en flop (reset 0) sets to 1 at the first posedge after reset release. in_ready = ready_en & ~hold_full.
- Accept: on a posedge with in_valid && in_ready, hold_byte <= in_byte and hold_full <= 1. in_byte is ignored when not accepted, and in_valid while in_ready=0 has no effect.
- State machine: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If hold_full, load shift register from hold_byte, clear hold_full and go to START.
    - Accept and load in the same cycle: hold_byte takes the new byte and hold_full stays 1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each for CLKS_PER_BIT cycles. The bit counter runs 0..7.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - At the final stop cycle, pulse frame_done on the next cycle.
    - If hold_full, load directly and enter START with no IDLE cycle; otherwise go to IDLE.
- tx is registered and tracks the state so that each bit level lasts exactly CLKS_PER_BIT cycles.
- Latency: a byte accepted at edge N while IDLE and the register was empty gives tx=0 after edge N+2 (edge N+1 loads, edge N+2 drives the start bit).
- Frame length is exactly (9+STOP_BITS)*CLKS_PER_BIT cycles. A continuous stream has period (9+STOP_BITS)*CLKS_PER_BIT per byte.
- Baud counter:
  - Width is ceil(log2(CLKS_PER_BIT)) bits, minimum 1.
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
  - Never counts in IDLE.
- busy = (state != IDLE) | hold_full, registered, so it lags the state by at most one cycle. busy must be 0 exactly when tx idles with nothing pending.
- Full holding register while a frame is in flight: in_ready=0 until the holding register is loaded into the shifter at the stop/IDLE boundary. No byte is ever dropped or overwritten.
- Reset mid-frame: tx returns high immediately, the in-flight and held bytes are discarded, and in_ready is 0 until one edge after release.
- The block has no framing knowledge. Header and footer bytes are ordinary data.

Test Plan:
- Single byte, CLKS_PER_BIT=4, STOP_BITS=1, send 0x0A: tx sequence, each level for 4 cycles, is 0 (start), 0,1,0,1,0,0,0,0, 1 (stop), i.e. 40 cycles. frame_done pulses once, busy then falls, and tx stays 1.
- Back-to-back, CLKS_PER_BIT=4, in_valid held high with 0x55 then 0xFA:
  - Second start bit begins the cycle immediately after the first stop bit ends; total 80 cycles from the first start bit.
  - 0xFA data bits are 0,1,0,1,1,1,1,1.
- Backpressure, stream 0A 55 FA CE with in_valid held high:
  - in_ready goes low after the second accept and rises once per frame boundary.
  - Exactly 4 frames appear in order with 4 frame_done pulses.
- STOP_BITS=2, CLKS_PER_BIT=3, send 0xCE: stop high for 6 cycles, frame 33 cycles; data bits 0,1,1,1,0,0,1,1.
- Reset mid-DATA (bit 3 of 0xA2) with a byte held:
  - tx=1 asynchronously, busy=0, in_ready=0 during reset and 1 one edge after release.
  - A new byte 0x5E then transmits correctly with no residue.
- Reset release with in_valid=1: no accept on the first edge; accept occurs on the second edge.
